pixel_pattern_gen: RTL and testbench
====================================

Name: pixel_pattern_gen

Overview:
Synthetic RGB pixel source that sits directly upstream of the AXI-Stream video packer. Drives r/g/b plus valid/sof/eol and honours the packer's ready backpressure. Produces full frames of a selectable test pattern for bring-up of the video output path and the CNN input path without a camera. All pixel outputs are registered, with one output holding register and a frame-level FSM.

Parameters:
IMG_W, 640, active pixels per line; must be a multiple of 8 and >= 8
IMG_H, 480, lines per frame; >= 1
XW, 10, x counter width; 2**XW >= IMG_W
YW, 9, y counter width; 2**YW >= IMG_H

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  asynchronous, active-high reset
enable  in  1  level; 1 = generate frames continuously
pattern_sel  in  2  0 colour bars, 1 gradient, 2 checkerboard, 3 solid
r  out  8  red
g  out  8  green
b  out  8  blue
valid  out  1  pixel on r/g/b is valid
sof  out  1  first pixel of frame (x=0, y=0); qualified by valid
eol  out  1  last pixel of line (x=IMG_W-1); qualified by valid
ready  in  1  downstream accepts the pixel this cycle
frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted
frame_count  out  16  completed frames; wraps 0xFFFF -> 0

Behaviour:
- Reset (async assert, sync-safe release): state IDLE; x, y, bar = 0; r/g/b = 0; valid/sof/eol/frame_done = 0; frame_count = 0; latched pattern = 0.
- Transfer = valid & ready on a rising edge. While valid=1 and ready=0, r/g/b/sof/eol hold stable. valid never drops without a transfer.
- Output register loads the next pixel when (!valid | ready) and a pixel is pending.
- FSM IDLE: enable=1 sampled -> RUN. pattern_sel is latched into pat_q on that edge. Output register loads pixel (0,0) with sof=1, valid=1. Latency: valid rises 1 cycle after enable is first sampled high.
- FSM RUN: each transfer advances x. When x=IMG_W-1, x -> 0 and y increments.
- On transfer of pixel (IMG_W-1, IMG_H-1):
  - frame_done = 1 on the next cycle; frame_count += 1 on the same edge.
  - If enable=1: re-latch pattern_sel and load pixel (0,0) of the next frame on the same edge. No bubble; valid stays 1.
  - Else: valid -> 0, state -> IDLE.
- enable deasserted mid-frame: the current frame completes; stopping happens only at a frame boundary. pattern_sel changes mid-frame are ignored.
- Pixel function uses pat_q and the coordinates of the pixel being loaded:
  - 0 colour bars: bar index i = x / (IMG_W/8), tracked with a bar counter and a within-bar counter, no divider. r = FF if i in {0,1,4,5}; g = FF if i in {0,1,2,3}; b = FF if i in {0,2,4,6}; otherwise 00. Sequence is white, yellow, cyan, green, magenta, red, blue, black.
  - 1 gradient: r = x[7:0], g = y[7:0], b = (x+y)[7:0]; truncation, wrap permitted.
  - 2 checkerboard: FFFFFF if x[3] ^ y[3] ^ frame_count[0], else 000000. Squares are 8x8 and invert every frame.
  - 3 solid: r = g = b = frame_count[7:0].
- sof = (x==0 & y==0); eol = (x==IMG_W-1). Both registered with the pixel.
- IMG_W=8 and IMG_H=1 must work, including single-line frames where eol and the frame end coincide.
- areset asserted mid-frame: immediate return to reset values; the downstream sees valid drop asynchronously.

Decomposition:
- Shared package (pixel_pkg): PAT_BARS/PAT_GRAD/PAT_CHECK/PAT_SOLID encodings, FSM state encoding (IDLE, RUN), colour bar lookup constants.
- One sub-module: pattern_pixel_fn, a pure combinational map (pat, x, y, bar, frame_lsbs) -> r, g, b. This lets the pixel function be unit-checked separately from the handshake and FSM.

Test Plan:
- IMG_W=16, IMG_H=2, pat 0, ready=1, enable pulsed for 3 cycles -> exactly 32 transfers. Pixels 0-1 are FFFFFF, pixels 2-3 are FFFF00, and so on, ending with 000000. sof only on transfer 0; eol on transfers 15 and 31; frame_done one cycle after transfer 31; frame_count=1; then valid=0.
- Random ready (50%), pat 1, 2 frames, enable held -> every accepted pixel has r=x, g=y, b=x+y. Data is stable across stalls. The first frame-2 pixel directly follows the last frame-1 pixel with no bubble when ready=1.
- ready=0 held for 20 cycles at pixel (5,1) -> r/g/b/sof/eol/valid unchanged for all 20 cycles. x advances only after ready=1.
- pattern_sel switched 0->3 at pixel 10 of frame 0 -> frame 0 is bars throughout. Frame 1 is solid 01_01_01 (frame_count=1).
- pat 2, 2 frames -> pixel (8,0) is FFFFFF in frame 0 and 000000 in frame 1.
- areset pulsed mid-line, then enable -> all outputs return to 0 immediately. The restart begins at (0,0) with sof=1 and frame_count=0.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared encodings for the synthetic RGB pattern source: pattern select values,
// frame FSM states and the colour-bar lookup masks.
package pixel_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GRAD  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pat_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Bit i of each mask says whether that channel is full-scale in bar i
    // (white, yellow, cyan, green, magenta, red, blue, black).
    localparam logic [7:0] BAR_R_MASK = 8'b0011_0011;
    localparam logic [7:0] BAR_G_MASK = 8'b0000_1111;
    localparam logic [7:0] BAR_B_MASK = 8'b0101_0101;

    function automatic logic [7:0] bar_level(input logic [7:0] mask, input logic [2:0] idx);
        return mask[idx] ? 8'hFF : 8'h00;
    endfunction

endpackage

// File: rtl/pixel_pattern_gen_if.sv
// Pixel stream between the pattern source (master) and the video packer (slave).
interface pixel_pattern_gen_if;

    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       valid;
    logic       sof;
    logic       eol;
    logic       ready;

    modport master (
        output r, g, b, valid, sof, eol,
        input  ready
    );

    modport slave (
        input  r, g, b, valid, sof, eol,
        output ready
    );

endinterface

// File: rtl/pattern_pixel_fn.sv
// Pure combinational pixel colour function; every pattern depends only on the
// low eight bits of the coordinates, so only those are passed in.
module pattern_pixel_fn
    import pixel_pkg::*;
(
    input  pat_e       pat_i,
    input  logic [7:0] x_i,
    input  logic [7:0] y_i,
    input  logic [2:0] bar_i,
    input  logic [7:0] frame_lsbs_i,
    output logic [7:0] r_o,
    output logic [7:0] g_o,
    output logic [7:0] b_o
);

    logic [7:0] sum_s;
    logic       check_s;

    assign sum_s   = x_i + y_i;
    assign check_s = x_i[3] ^ y_i[3] ^ frame_lsbs_i[0];

    // colour selection per pattern
    always_comb begin
        r_o = 8'h00;
        g_o = 8'h00;
        b_o = 8'h00;
        case (pat_i)
            PAT_BARS: begin
                r_o = bar_level(BAR_R_MASK, bar_i);
                g_o = bar_level(BAR_G_MASK, bar_i);
                b_o = bar_level(BAR_B_MASK, bar_i);
            end
            PAT_GRAD: begin
                r_o = x_i;
                g_o = y_i;
                b_o = sum_s;
            end
            PAT_CHECK: begin
                r_o = check_s ? 8'hFF : 8'h00;
                g_o = check_s ? 8'hFF : 8'h00;
                b_o = check_s ? 8'hFF : 8'h00;
            end
            PAT_SOLID: begin
                r_o = frame_lsbs_i;
                g_o = frame_lsbs_i;
                b_o = frame_lsbs_i;
            end
            default: begin
                r_o = 8'h00;
                g_o = 8'h00;
                b_o = 8'h00;
            end
        endcase
    end

endmodule

// File: rtl/pixel_pattern_gen.sv
// Synthetic RGB frame source with a registered output stage, ready backpressure
// and a frame-level IDLE/RUN FSM that only stops at frame boundaries.
module pixel_pattern_gen
    import pixel_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int XW    = 10,
    parameter int YW    = 9
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                enable,
    input  logic [1:0]          pattern_sel,
    pixel_pattern_gen_if.master pix,
    output logic                frame_done,
    output logic [15:0]         frame_count
);

    localparam int             BAR_W    = IMG_W / 8;
    localparam logic [XW-1:0]  X_LAST   = XW'(IMG_W - 1);
    localparam logic [YW-1:0]  Y_LAST   = YW'(IMG_H - 1);
    localparam logic [XW-1:0]  BAR_LAST = XW'(BAR_W - 1);
    localparam logic [XW-1:0]  X_ONE    = XW'(1'b1);
    localparam logic [YW-1:0]  Y_ONE    = YW'(1'b1);

    state_e        state_q;
    pat_e          pat_q;
    logic [XW-1:0] x_q;
    logic [XW-1:0] x_d;
    logic [YW-1:0] y_q;
    logic [YW-1:0] y_d;
    logic [2:0]    bar_q;
    logic [2:0]    bar_d;
    logic [XW-1:0] bar_cnt_q;
    logic [XW-1:0] bar_cnt_d;
    logic [7:0]    r_q;
    logic [7:0]    g_q;
    logic [7:0]    b_q;
    logic          valid_q;
    logic          sof_q;
    logic          eol_q;
    logic          last_q;
    logic          frame_done_q;
    logic [15:0]   frame_count_q;

    logic          xfer_s;
    logic          frame_end_s;
    logic          start_s;
    logic          load_s;
    logic [15:0]   frame_count_inc_s;
    pat_e          fn_pat_s;
    logic [7:0]    fn_frame_s;
    logic [7:0]    fn_r_s;
    logic [7:0]    fn_g_s;
    logic [7:0]    fn_b_s;
    logic [7:0]    x_lsb_s;
    logic [7:0]    y_lsb_s;

    assign xfer_s            = valid_q & pix.ready;
    assign frame_end_s       = (state_q == ST_RUN) & xfer_s & last_q;
    assign frame_count_inc_s = frame_count_q + 16'd1;
    assign x_lsb_s           = 8'(x_q);
    assign y_lsb_s           = 8'(y_q);

    // When to load the holding register; a new frame takes the live pattern_sel
    // and, when it follows a completed frame, the already-incremented frame count.
    always_comb begin
        start_s = 1'b0;
        load_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                start_s = enable;
                load_s  = enable;
            end
            ST_RUN: begin
                start_s = frame_end_s & enable;
                load_s  = xfer_s & (~last_q | enable);
            end
            default: begin
                start_s = 1'b0;
                load_s  = 1'b0;
            end
        endcase
        if (start_s) begin
            fn_pat_s = pat_e'(pattern_sel);
        end else begin
            fn_pat_s = pat_q;
        end
        if (frame_end_s) begin
            fn_frame_s = frame_count_inc_s[7:0];
        end else begin
            fn_frame_s = frame_count_q[7:0];
        end
    end

    // Counters always hold the coordinates of the next pixel to load, wrapping
    // to (0,0) after the last pixel so a new frame needs no extra clear.
    always_comb begin
        x_d       = x_q + X_ONE;
        y_d       = y_q;
        bar_d     = bar_q;
        bar_cnt_d = bar_cnt_q + X_ONE;
        if (x_q == X_LAST) begin
            x_d       = '0;
            bar_d     = 3'd0;
            bar_cnt_d = '0;
            if (y_q == Y_LAST) begin
                y_d = '0;
            end else begin
                y_d = y_q + Y_ONE;
            end
        end else if (bar_cnt_q == BAR_LAST) begin
            bar_cnt_d = '0;
            bar_d     = bar_q + 3'd1;
        end else begin
            bar_d = bar_q;
        end
    end

    pattern_pixel_fn u_pixel_fn (
        .pat_i        (fn_pat_s),
        .x_i          (x_lsb_s),
        .y_i          (y_lsb_s),
        .bar_i        (bar_q),
        .frame_lsbs_i (fn_frame_s),
        .r_o          (fn_r_s),
        .g_o          (fn_g_s),
        .b_o          (fn_b_s)
    );

    // frame FSM, coordinate counters and output holding register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q       <= ST_IDLE;
            pat_q         <= PAT_BARS;
            x_q           <= '0;
            y_q           <= '0;
            bar_q         <= 3'd0;
            bar_cnt_q     <= '0;
            r_q           <= 8'h00;
            g_q           <= 8'h00;
            b_q           <= 8'h00;
            valid_q       <= 1'b0;
            sof_q         <= 1'b0;
            eol_q         <= 1'b0;
            last_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (frame_end_s) begin
                        frame_done_q  <= 1'b1;
                        frame_count_q <= frame_count_inc_s;
                        if (!enable) begin
                            state_q <= ST_IDLE;
                            valid_q <= 1'b0;
                            sof_q   <= 1'b0;
                            eol_q   <= 1'b0;
                            last_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (start_s) begin
                pat_q <= fn_pat_s;
            end
            if (load_s) begin
                x_q       <= x_d;
                y_q       <= y_d;
                bar_q     <= bar_d;
                bar_cnt_q <= bar_cnt_d;
                r_q       <= fn_r_s;
                g_q       <= fn_g_s;
                b_q       <= fn_b_s;
                valid_q   <= 1'b1;
                sof_q     <= (x_q == '0) && (y_q == '0);
                eol_q     <= (x_q == X_LAST);
                last_q    <= (x_q == X_LAST) && (y_q == Y_LAST);
            end
        end
    end

    assign pix.r       = r_q;
    assign pix.g       = g_q;
    assign pix.b       = b_q;
    assign pix.valid   = valid_q;
    assign pix.sof     = sof_q;
    assign pix.eol     = eol_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_pixel_pattern_gen.sv
// Directed bench for pixel_pattern_gen on a 16x2 frame: a stream monitor checks
// every accepted pixel, stall stability and frame_done/frame_count each cycle.
module tb_pixel_pattern_gen;

    localparam int W  = 16;
    localparam int H  = 2;
    localparam int XW = 4;
    localparam int YW = 1;

    localparam logic [23:0] BARS [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        frame_done;
    logic [15:0] frame_count;

    pixel_pattern_gen_if pix ();

    pixel_pattern_gen #(.IMG_W(W), .IMG_H(H), .XW(XW), .YW(YW)) dut (
        .aclk        (aclk),
        .areset      (areset),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .pix         (pix),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    always #5 aclk = ~aclk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_x, exp_y, exp_fc, exp_pat, exp_pat_next, n_xfer, fd_cnt, sw_at;
    bit          exp_done, mon_en, stall_en, stall_checked;
    bit          p_valid, p_ready, p_enable;
    logic [26:0] p_out;
    logic [23:0] cap8 [0:3];
    logic [23:0] capfirst [0:3];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] model(input int pat, input int x, input int y, input int fc);
        logic [7:0] xs, ys, fs;
        xs = 8'(x);
        ys = 8'(y);
        fs = 8'(fc);
        case (pat)
            0:       model = BARS[x / (W / 8)];
            1:       model = {xs, ys, 8'(xs + ys)};
            2:       model = (xs[3] ^ ys[3] ^ fs[0]) ? 24'hFFFFFF : 24'h000000;
            default: model = {fs, fs, fs};
        endcase
    endfunction

    task automatic mon_sample();
        logic [23:0] rgb;
        logic [26:0] cur;
        rgb = {pix.r, pix.g, pix.b};
        cur = {pix.valid, pix.sof, pix.eol, rgb};
        if (mon_en) begin
            if (p_valid && !p_ready) check_val("stall_hold", 32'(cur), 32'(p_out));
            if (p_valid && !(p_ready && exp_done && !p_enable)) check_val("valid_held", 32'(pix.valid), 32'd1);
            check_val("frame_done", 32'(frame_done), 32'(exp_done));
            check_val("frame_count", 32'(frame_count), 32'(exp_fc));
            if (frame_done) fd_cnt++;
            exp_done = 1'b0;
            if (pix.valid && pix.ready) begin
                check_val("pixel", 32'(rgb), 32'(model(exp_pat, exp_x, exp_y, exp_fc)));
                check_val("sof", 32'(pix.sof), 32'(exp_x == 0 && exp_y == 0));
                check_val("eol", 32'(pix.eol), 32'(exp_x == W - 1));
                if (exp_x == 8 && exp_y == 0 && exp_fc < 4) cap8[exp_fc] = rgb;
                if (exp_x == 0 && exp_y == 0 && exp_fc < 4) capfirst[exp_fc] = rgb;
                n_xfer++;
                if (exp_x == W - 1) begin
                    exp_x = 0;
                    if (exp_y == H - 1) begin
                        exp_y = 0;
                        exp_done = 1'b1;
                        exp_fc++;
                        exp_pat = exp_pat_next;
                    end else begin
                        exp_y++;
                    end
                end else begin
                    exp_x++;
                end
            end
            p_valid  = pix.valid;
            p_ready  = pix.ready;
            p_enable = enable;
            p_out    = cur;
        end
    endtask

    task automatic tick();
        @(negedge aclk);
        mon_sample();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        enable = 1'b0;
        pix.ready = 1'b1;
        pattern_sel = 2'd0;
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        exp_x = 0; exp_y = 0; exp_fc = 0; n_xfer = 0; fd_cnt = 0;
        exp_done = 1'b0; p_valid = 1'b0; p_ready = 1'b0; p_enable = 1'b0; p_out = '0;
        for (int i = 0; i < 4; i++) begin
            cap8[i] = 24'hA5A5A5;
            capfirst[i] = 24'hA5A5A5;
        end
        mon_en = 1'b1;
    endtask

    task automatic set_pattern(input int pat);
        pattern_sel = 2'(pat);
        exp_pat = pat;
        exp_pat_next = pat;
    endtask

    // Runs n frames with enable held, dropping enable inside the last frame.
    task automatic run_frames(input int n, input bit rnd);
        int fc0, cyc, stall_cnt;
        bit stall_done;
        fc0 = exp_fc; cyc = 0; stall_cnt = 0; stall_done = 1'b0;
        enable = 1'b1;
        pix.ready = 1'b1;
        while (cyc < 3000 && !(exp_fc - fc0 == n && !pix.valid)) begin
            tick();
            cyc++;
            if (exp_fc - fc0 == n - 1 && (exp_x != 0 || exp_y != 0)) enable = 1'b0;
            if (sw_at >= 0 && n_xfer == sw_at) begin
                pattern_sel = 2'd3;
                exp_pat_next = 3;
                sw_at = -1;
            end
            if (stall_en && !stall_done && pix.valid && exp_x == 5 && exp_y == 1) begin
                stall_done = 1'b1;
                stall_cnt = 20;
            end
            if (stall_cnt > 0) begin
                pix.ready = 1'b0;
                stall_cnt--;
            end else begin
                if (stall_done && !stall_checked) begin
                    check_val("stall_pos", 32'(exp_x * 16 + exp_y), 32'd81);
                    check_val("stall_valid", 32'(pix.valid), 32'd1);
                    stall_checked = 1'b1;
                end
                pix.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        check_val("frames_run", 32'(exp_fc - fc0), 32'(n));
        check_val("stopped", 32'(pix.valid), 32'd0);
        pix.ready = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        int cyc;
        sw_at = -1;
        stall_en = 1'b0;
        stall_checked = 1'b0;
        set_pattern(0);

        do_reset();
        check_val("rst_valid", 32'(pix.valid), 32'd0);
        check_val("rst_sof", 32'(pix.sof), 32'd0);
        check_val("rst_eol", 32'(pix.eol), 32'd0);
        check_val("rst_rgb", 32'({pix.r, pix.g, pix.b}), 32'd0);
        check_val("rst_done", 32'(frame_done), 32'd0);
        check_val("rst_count", 32'(frame_count), 32'd0);

        // colour bars, enable pulsed for three cycles -> exactly one frame
        set_pattern(0);
        enable = 1'b1;
        tick();
        check_val("latency_valid", 32'(pix.valid), 32'd1);
        check_val("latency_sof", 32'(pix.sof), 32'd1);
        tick();
        tick();
        enable = 1'b0;
        cyc = 0;
        while (cyc < 200 && !(exp_fc == 1 && !pix.valid)) begin
            tick();
            cyc++;
        end
        check_val("bars_xfers", 32'(n_xfer), 32'd32);
        check_val("bars_count", 32'(frame_count), 32'd1);
        check_val("bars_valid_low", 32'(pix.valid), 32'd0);
        tick();
        tick();
        check_val("bars_done_pulses", 32'(fd_cnt), 32'd1);
        check_val("bars_first", 32'(capfirst[0]), 32'hFFFFFF);
        check_val("bars_x8", 32'(cap8[0]), 32'hFF00FF);

        // pattern change mid-frame only affects the next frame
        do_reset();
        set_pattern(0);
        sw_at = 10;
        run_frames(2, 1'b0);
        check_val("switch_f0", 32'(capfirst[0]), 32'hFFFFFF);
        check_val("switch_f1_solid", 32'(capfirst[1]), 32'h010101);

        // gradient with random backpressure over two frames
        do_reset();
        set_pattern(1);
        run_frames(2, 1'b1);
        check_val("grad_f1_x8", 32'(cap8[1]), 32'h080008);

        // long stall at pixel (5,1)
        do_reset();
        set_pattern(1);
        stall_en = 1'b1;
        run_frames(1, 1'b0);
        stall_en = 1'b0;
        check_val("stall_seen", 32'(stall_checked), 32'd1);

        // checkerboard inverts every frame
        do_reset();
        set_pattern(2);
        run_frames(2, 1'b0);
        check_val("check_f0_x8", 32'(cap8[0]), 32'hFFFFFF);
        check_val("check_f1_x8", 32'(cap8[1]), 32'h000000);

        // asynchronous reset in the middle of a line of frame 1
        do_reset();
        set_pattern(0);
        enable = 1'b1;
        cyc = 0;
        while (cyc < 200 && !(exp_fc == 1 && exp_x == 5)) begin
            tick();
            cyc++;
        end
        check_val("mid_reached", 32'(exp_fc * 100 + exp_x), 32'd105);
        check_val("mid_count", 32'(frame_count), 32'd1);
        mon_en = 1'b0;
        #2;
        areset = 1'b1;
        #1;
        check_val("async_valid", 32'(pix.valid), 32'd0);
        check_val("async_rgb", 32'({pix.r, pix.g, pix.b}), 32'd0);
        check_val("async_sof_eol", 32'({pix.sof, pix.eol}), 32'd0);
        check_val("async_count", 32'(frame_count), 32'd0);
        do_reset();
        set_pattern(0);
        run_frames(1, 1'b0);
        check_val("restart_first", 32'(capfirst[0]), 32'hFFFFFF);
        check_val("restart_count", 32'(frame_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
